// File: rtl/sdr_write_packer_if.sv
// Job control, result stream and SDR burst-write signals of sdr_write_packer.
// master: the packer side. slave: the ray core plus the SDR bridge around it.
interface sdr_write_packer_if #(
    parameter int DATA_W    = 32,
    parameter int BUF_WORDS = 64
);
    logic                          start;
    logic [31:0]                   base_addr;
    logic [29:0]                   total_words;
    logic [DATA_W-1:0]             in_data;
    logic                          in_valid;
    logic                          in_ready;
    logic                          flush;
    logic [31:0]                   sdr_baseaddr;
    logic [29:0]                   sdr_nelems;
    logic [DATA_W*BUF_WORDS-1:0]   sdr_writedata;
    logic                          sdr_writestart;
    logic                          sdr_writeend;
    logic                          busy;
    logic                          done;
    logic                          err;

    modport master (
        input  start, base_addr, total_words, in_data, in_valid, flush, sdr_writeend,
        output in_ready, sdr_baseaddr, sdr_nelems, sdr_writedata, sdr_writestart,
               busy, done, err
    );

    modport slave (
        output start, base_addr, total_words, in_data, in_valid, flush, sdr_writeend,
        input  in_ready, sdr_baseaddr, sdr_nelems, sdr_writedata, sdr_writestart,
               busy, done, err
    );
endinterface

// File: rtl/sdr_write_packer.sv
// Packs a 32-bit result stream into 2048-bit SDR write bursts (writestart/writeend handshake).
// Define SDR_WRITE_TIMEOUT_EN to add a writeend watchdog with an ERR state.
module sdr_write_packer #(
    parameter int DATA_W         = 32,
    parameter int BUF_WORDS      = 64,
    parameter int ADDR_STEP      = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                 sdr_clk,
    input  logic                 sdr_reset,
    sdr_write_packer_if.master   bus
);
    localparam int CNT_W = $clog2(BUF_WORDS + 1);
    localparam int IDX_W = $clog2(BUF_WORDS);

`ifdef SDR_WRITE_TIMEOUT_EN
    typedef enum logic [2:0] {S_IDLE, S_FILL, S_ISSUE, S_WAIT, S_DONE, S_ERR} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_FILL, S_ISSUE, S_WAIT, S_DONE} state_t;
`endif

    state_t                             state;
    logic [BUF_WORDS-1:0][DATA_W-1:0]   slots;
    logic [CNT_W-1:0]                   count;
    logic [29:0]                        remaining;
    logic [31:0]                        cur_addr;
    logic                               in_ready_q;
    logic [31:0]                        baseaddr_q;
    logic [29:0]                        nelems_q;
    logic                               writestart_q;
    logic                               busy_q;
    logic                               done_q;
`ifdef SDR_WRITE_TIMEOUT_EN
    logic                               err_q;
    logic [15:0]                        wdog;
`endif

    logic             accept;
    logic [CNT_W-1:0] cnt_nxt;
    logic [29:0]      rem_nxt;
    logic             go_issue;

    // in_ready_q is only ever high in FILL, so accept implies FILL.
    always_comb begin
        accept   = bus.in_valid & in_ready_q;
        cnt_nxt  = count + CNT_W'(accept);
        rem_nxt  = remaining - 30'(accept);
        go_issue = (accept && (cnt_nxt == CNT_W'(BUF_WORDS) || rem_nxt == '0)) ||
                   (bus.flush && cnt_nxt != '0);
    end

    always_ff @(posedge sdr_clk or posedge sdr_reset) begin
        if (sdr_reset) begin
            state        <= S_IDLE;
            slots        <= '0;
            count        <= '0;
            remaining    <= '0;
            cur_addr     <= '0;
            in_ready_q   <= 1'b0;
            baseaddr_q   <= '0;
            nelems_q     <= '0;
            writestart_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
`ifdef SDR_WRITE_TIMEOUT_EN
            err_q        <= 1'b0;
            wdog         <= '0;
`endif
        end else begin
            writestart_q <= 1'b0;
            case (state)
                S_FILL: begin
                    if (accept) begin
                        slots[count[IDX_W-1:0]] <= bus.in_data;
                        count     <= cnt_nxt;
                        remaining <= rem_nxt;
                    end
                    if (go_issue) begin
                        in_ready_q   <= 1'b0;
                        writestart_q <= 1'b1;
                        baseaddr_q   <= cur_addr;
                        nelems_q     <= 30'(cnt_nxt);
                        state        <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    state <= S_WAIT;
`ifdef SDR_WRITE_TIMEOUT_EN
                    wdog  <= '0;
`endif
                end
                S_WAIT: begin
                    if (bus.sdr_writeend) begin
                        cur_addr <= cur_addr + 32'(count) * 32'(ADDR_STEP);
                        slots    <= '0;
                        count    <= '0;
                        if (remaining == '0) begin
                            state  <= S_DONE;
                            done_q <= 1'b1;
                            busy_q <= 1'b0;
                        end else begin
                            state      <= S_FILL;
                            in_ready_q <= 1'b1;
                        end
                    end
`ifdef SDR_WRITE_TIMEOUT_EN
                    // Decide one cycle early so err is visible on the last counted WAIT cycle.
                    else if (32'(wdog) + 32'd2 >= 32'(TIMEOUT_CYCLES)) begin
                        state  <= S_ERR;
                        err_q  <= 1'b1;
                        busy_q <= 1'b0;
                    end else begin
                        wdog <= wdog + 16'd1;
                    end
`endif
                end
                default: begin
                    // IDLE, DONE (and ERR): wait for a new job.
                    if (bus.start) begin
                        cur_addr  <= bus.base_addr;
                        remaining <= bus.total_words;
                        slots     <= '0;
                        count     <= '0;
`ifdef SDR_WRITE_TIMEOUT_EN
                        err_q     <= 1'b0;
`endif
                        if (bus.total_words == '0) begin
                            state  <= S_DONE;
                            done_q <= 1'b1;
                            busy_q <= 1'b0;
                        end else begin
                            state      <= S_FILL;
                            done_q     <= 1'b0;
                            busy_q     <= 1'b1;
                            in_ready_q <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign bus.in_ready       = in_ready_q;
    assign bus.sdr_baseaddr   = baseaddr_q;
    assign bus.sdr_nelems     = nelems_q;
    assign bus.sdr_writedata  = slots;
    assign bus.sdr_writestart = writestart_q;
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
`ifdef SDR_WRITE_TIMEOUT_EN
    assign bus.err            = err_q;
`else
    assign bus.err            = 1'b0;
`endif
endmodule

// File: tb/tb_sdr_write_packer.sv
// Directed bench for sdr_write_packer: table of burst jobs plus hand-written corner sequences.
module tb_sdr_write_packer;
    localparam int DW = 32;
    localparam int BW = 64;

    logic sdr_clk = 1'b0;
    logic sdr_reset = 1'b1;
    always #5 sdr_clk = ~sdr_clk;

    sdr_write_packer_if #(.DATA_W(DW), .BUF_WORDS(BW)) bus ();

    sdr_write_packer #(
        .DATA_W(DW), .BUF_WORDS(BW), .ADDR_STEP(4), .TIMEOUT_CYCLES(100)
    ) dut (
        .sdr_clk  (sdr_clk),
        .sdr_reset(sdr_reset),
        .bus      (bus.master)
    );

    int total_n = 0;
    int bad_n   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_n++;
        if (act !== exp) begin
            bad_n++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge sdr_clk);
        #1;
    endtask

    typedef struct {
        logic [31:0]      base;
        int               total;
        int               flush_at;   // word index whose accept carries flush, -1 = none
        int               nb;
        logic [2:0][7:0]  n;
        logic [2:0][31:0] a;
    } vec_t;

    vec_t vt[5];

    task automatic run_job(input vec_t v, input string tag);
        int w, nb, cd, bw, nn;
        logic ir_bad, acc;
        logic [DW*BW-1:0] wd;
        bus.start = 1'b1; bus.base_addr = v.base; bus.total_words = 30'(v.total);
        step();
        bus.start = 1'b0;
        w = 0; nb = 0; cd = -1; bw = 0; ir_bad = 1'b0;
        for (int cyc = 0; cyc < 3000 && !bus.done; cyc++) begin
            bus.in_valid     = (w < v.total);
            bus.in_data      = DW'(w);
            acc              = bus.in_valid && bus.in_ready;
            bus.flush        = acc && (w == v.flush_at);
            bus.sdr_writeend = (cd == 0);
            step();
            if (acc) w++;
            if (cd > 0) begin
                if (bus.in_ready) ir_bad = 1'b1;
                cd--;
            end else if (cd == 0) cd = -1;
            if (bus.sdr_writestart) begin
                if (nb < 3) begin
                    nn = int'(v.n[nb]);
                    wd = bus.sdr_writedata;
                    chk($sformatf("%s nelems%0d", tag, nb), 64'(bus.sdr_nelems), 64'(nn));
                    chk($sformatf("%s addr%0d", tag, nb), 64'(bus.sdr_baseaddr), 64'(v.a[nb]));
                    chk($sformatf("%s first%0d", tag, nb), 64'(wd[31:0]), 64'(bw));
                    chk($sformatf("%s last%0d", tag, nb), 64'(wd[32*(nn-1) +: 32]), 64'(bw + nn - 1));
                    if (nn < BW)
                        chk($sformatf("%s zerofill%0d", tag, nb), 64'((wd >> (32*nn)) == '0), 64'(1));
                    bw += nn;
                end
                nb++;
                cd = 10;
            end
        end
        bus.in_valid = 1'b0; bus.flush = 1'b0; bus.sdr_writeend = 1'b0;
        chk({tag, " bursts"}, 64'(nb), 64'(v.nb));
        chk({tag, " words"}, 64'(w), 64'(v.total));
        chk({tag, " done"}, 64'(bus.done), 64'(1));
        chk({tag, " busy"}, 64'(bus.busy), 64'(0));
        chk({tag, " in_ready_in_wait"}, 64'(ir_bad), 64'(0));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " in_ready"}, 64'(bus.in_ready), 64'(0));
        chk({tag, " busy"}, 64'(bus.busy), 64'(0));
        chk({tag, " done"}, 64'(bus.done), 64'(0));
        chk({tag, " err"}, 64'(bus.err), 64'(0));
        chk({tag, " writestart"}, 64'(bus.sdr_writestart), 64'(0));
        chk({tag, " nelems"}, 64'(bus.sdr_nelems), 64'(0));
        chk({tag, " baseaddr"}, 64'(bus.sdr_baseaddr), 64'(0));
        chk({tag, " writedata"}, 64'(bus.sdr_writedata == '0), 64'(1));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no finish want finish");
        $fatal(1);
    end

    initial begin
        vt[0] = '{base: 32'h1000, total: 64, flush_at: -1, nb: 1,
                  n: {8'd0, 8'd0, 8'd64}, a: {32'h0, 32'h0, 32'h1000}};
        vt[1] = '{base: 32'h1000, total: 130, flush_at: -1, nb: 3,
                  n: {8'd2, 8'd64, 8'd64}, a: {32'h1200, 32'h1100, 32'h1000}};
        vt[2] = '{base: 32'h2000, total: 100, flush_at: 4, nb: 3,
                  n: {8'd31, 8'd64, 8'd5}, a: {32'h2114, 32'h2014, 32'h2000}};
        vt[3] = '{base: 32'hFFFF_FFF0, total: 70, flush_at: -1, nb: 2,
                  n: {8'd0, 8'd6, 8'd64}, a: {32'h0, 32'h0000_00F0, 32'hFFFF_FFF0}};
        vt[4] = '{base: 32'h40, total: 1, flush_at: -1, nb: 1,
                  n: {8'd0, 8'd0, 8'd1}, a: {32'h0, 32'h0, 32'h40}};

        bus.start = 1'b0; bus.base_addr = '0; bus.total_words = '0;
        bus.in_data = '0; bus.in_valid = 1'b0; bus.flush = 1'b0; bus.sdr_writeend = 1'b0;
        step(); step();
        chk_all_zero("reset");
        sdr_reset = 1'b0;
        step();

        for (int i = 0; i < 5; i++) run_job(vt[i], $sformatf("vec%0d", i));

        // Zero-length job: done next cycle, no burst.
        bus.start = 1'b1; bus.base_addr = 32'h5000; bus.total_words = '0;
        step();
        bus.start = 1'b0;
        chk("zero done", 64'(bus.done), 64'(1));
        chk("zero busy", 64'(bus.busy), 64'(0));
        chk("zero writestart", 64'(bus.sdr_writestart), 64'(0));
        bus.sdr_writeend = 1'b1;
        step();
        bus.sdr_writeend = 1'b0;
        chk("writeend_in_done done", 64'(bus.done), 64'(1));
        chk("writeend_in_done writestart", 64'(bus.sdr_writestart), 64'(0));

        // writeend in FILL and coincident with ISSUE must be ignored; flush on empty buffer too.
        bus.start = 1'b1; bus.base_addr = 32'h300; bus.total_words = 30'd3;
        step();
        bus.start = 1'b0;
        chk("fill in_ready", 64'(bus.in_ready), 64'(1));
        bus.sdr_writeend = 1'b1;
        step();
        bus.sdr_writeend = 1'b0;
        chk("writeend_in_fill in_ready", 64'(bus.in_ready), 64'(1));
        chk("writeend_in_fill busy", 64'(bus.busy), 64'(1));
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        chk("empty_flush writestart", 64'(bus.sdr_writestart), 64'(0));
        chk("empty_flush in_ready", 64'(bus.in_ready), 64'(1));
        for (int k = 0; k < 3; k++) begin
            bus.in_valid = 1'b1; bus.in_data = DW'(32'hA0 + k);
            step();
        end
        bus.in_valid = 1'b0;
        chk("short writestart", 64'(bus.sdr_writestart), 64'(1));
        chk("short nelems", 64'(bus.sdr_nelems), 64'(3));
        chk("short addr", 64'(bus.sdr_baseaddr), 64'(32'h300));
        chk("short word2", 64'(bus.sdr_writedata[95:64]), 64'(32'hA2));
        bus.sdr_writeend = 1'b1;
        step();
        bus.sdr_writeend = 1'b0;
        step(); step();
        chk("issue_writeend busy", 64'(bus.busy), 64'(1));
        chk("issue_writeend done", 64'(bus.done), 64'(0));
        bus.sdr_writeend = 1'b1;
        step();
        bus.sdr_writeend = 1'b0;
        chk("short done", 64'(bus.done), 64'(1));
        chk("short next_base_unchanged", 64'(bus.sdr_baseaddr), 64'(32'h300));

        // Reset in WAIT clears everything immediately; a later writeend does nothing.
        bus.start = 1'b1; bus.base_addr = 32'h700; bus.total_words = 30'd2;
        step();
        bus.start = 1'b0;
        bus.in_valid = 1'b1; bus.in_data = 32'h11;
        step();
        bus.in_data = 32'h22;
        step();
        bus.in_valid = 1'b0;
        chk("prereset writestart", 64'(bus.sdr_writestart), 64'(1));
        step(); step();
        sdr_reset = 1'b1;
        #1;
        chk_all_zero("midwait_reset");
        step();
        sdr_reset = 1'b0;
        bus.sdr_writeend = 1'b1;
        step();
        bus.sdr_writeend = 1'b0;
        chk("late_writeend done", 64'(bus.done), 64'(0));
        chk("late_writeend busy", 64'(bus.busy), 64'(0));
        chk("late_writeend in_ready", 64'(bus.in_ready), 64'(0));
        run_job(vt[4], "post_reset");

`ifdef SDR_WRITE_TIMEOUT_EN
        begin
            int k;
            bus.start = 1'b1; bus.base_addr = 32'h900; bus.total_words = 30'd1;
            step();
            bus.start = 1'b0;
            bus.in_valid = 1'b1; bus.in_data = 32'h5;
            step();
            bus.in_valid = 1'b0;
            chk("wdog writestart", 64'(bus.sdr_writestart), 64'(1));
            k = 0;
            while (!bus.err && k < 200) begin
                step();
                k++;
            end
            chk("wdog cycle", 64'(k), 64'(100));
            chk("wdog busy", 64'(bus.busy), 64'(0));
            chk("wdog in_ready", 64'(bus.in_ready), 64'(0));
            bus.start = 1'b1; bus.total_words = '0;
            step();
            bus.start = 1'b0;
            chk("wdog err_cleared", 64'(bus.err), 64'(0));
            chk("wdog restart done", 64'(bus.done), 64'(1));
        end
`endif

        $display("test done: total=%0d bad=%0d", total_n, bad_n);
        $finish;
    end
endmodule

// File: doc/sdr_write_packer.md
Name: sdr_write_packer

Overview:
- Write-side counterpart of the SDRAM burst-read handshake (sdr_readstart/sdr_baseaddr/sdr_nelems/sdr_readdata/sdr_readend).
- Accepts a stream of 32-bit result words (e.g. ray-tracer pixels) and packs them into a 2048-bit burst buffer.
- Issues sdr_writestart bursts to the Computer_System SDR bridge and waits for sdr_writeend before refilling.
- Sits between the ray-tracing core and the sdr_* exports of the system top level.

Parameters:
- DATA_W, 32, width of one stream word.
- BUF_WORDS, 64, words per burst buffer; DATA_W*BUF_WORDS = 2048 = sdr_writedata width.
- ADDR_STEP, 4, byte-address increment per word.
- TIMEOUT_CYCLES, 65535, writeend watchdog limit (only used with the optional feature).

Ports:
- sdr_clk  in  1  clock.
- sdr_reset  in  1  asynchronous, active-high reset.
- start  in  1  begin a transfer job; sampled in IDLE or DONE.
- base_addr  in  32  job start byte address; latched on start.
- total_words  in  30  job length in words; latched on start.
- in_data  in  DATA_W  stream word.
- in_valid  in  1  stream word valid.
- in_ready  out  1  stream word accepted when in_valid & in_ready.
- flush  in  1  force the partially filled buffer out.
- sdr_baseaddr  out  32  burst byte address.
- sdr_nelems  out  30  words in the current burst.
- sdr_writedata  out  2048  burst payload; word k occupies bits [32k +: 32].
- sdr_writestart  out  1  one-cycle burst request.
- sdr_writeend  in  1  burst-complete pulse from the bridge.
- busy  out  1  job in progress.
- done  out  1  job complete; held until the next start.
- err  out  1  watchdog error (0 when the optional feature is off).

Behaviour:
- Reset: all outputs 0, buffer cleared, count 0, state IDLE. Reset is honoured in any state, including WAIT; any later sdr_writeend is ignored.
- All outputs are registered. States are IDLE, FILL, ISSUE, WAIT, DONE (plus ERR with the optional feature).
- IDLE/DONE, on start:
  - Latch cur_addr = base_addr and remaining = total_words; clear done; set busy.
  - If total_words == 0, go to DONE next cycle with no burst issued. Otherwise go to FILL.
  - start while busy is ignored.
- FILL:
  - in_ready = 1 (registered, asserted from the first FILL cycle).
  - On accept: slot[count] <= in_data; count++; remaining--.
  - Go to ISSUE when, after the accept, count == BUF_WORDS or remaining == 0.
  - Also go to ISSUE on flush when count > 0. The current-cycle accept is included in that burst.
  - flush with count == 0 is ignored.
  - in_ready deasserts on the cycle the transition to ISSUE is taken, so no word is accepted beyond the buffer.
- ISSUE (one cycle):
  - sdr_writestart = 1; sdr_baseaddr = cur_addr; sdr_nelems = count.
  - Unfilled slots are 0. Go to WAIT.
- WAIT:
  - sdr_writestart = 0. sdr_baseaddr, sdr_nelems and sdr_writedata stay stable. in_ready = 0.
  - On sdr_writeend:
    - cur_addr += count*ADDR_STEP (32-bit wrap, no saturation); clear buffer; count = 0.
    - If remaining == 0, go to DONE (done = 1, busy = 0). Else go to FILL.
- sdr_writeend outside WAIT is ignored, including a pulse coincident with ISSUE.
- flush outside FILL is ignored.

Optional Feature:
- Macro: SDR_WRITE_TIMEOUT_EN.
- Defined:
  - A 16-bit watchdog counts WAIT cycles.
  - Reaching TIMEOUT_CYCLES without sdr_writeend moves to ERR: err = 1, busy = 0, done = 0, in_ready = 0.
  - ERR exits only via reset or start; start clears err and begins a new job.
- Undefined: no counter and no ERR state; err is tied to 0; WAIT waits indefinitely.

Test Plan:
- start, base 0x1000, total 64; stream 0..63 -> one writestart pulse with sdr_baseaddr 0x1000, sdr_nelems 64, writedata[31:0]=0, [2047:2016]=63. writeend after 10 cycles -> done=1, busy=0.
- total 130, continuous stream -> three bursts at 0x1000, 0x1100, 0x1200 with nelems 64, 64, 2. Third burst writedata[2047:64]=0. in_ready=0 throughout every WAIT.
- total 100; flush asserted on the same cycle as the 5th accept -> burst nelems 5 at base. The next burst starts at base+20; the job finishes after 95 more words.
- start with total_words 0 -> done next cycle, no writestart. writeend pulse in IDLE/FILL -> no state change.
- sdr_reset asserted mid-WAIT -> all outputs 0 immediately; a later writeend is ignored; a new start works normally.
- With SDR_WRITE_TIMEOUT_EN, TIMEOUT_CYCLES=100, writeend withheld -> err=1 on WAIT cycle 100, busy=0; start clears err.
